// File: rtl/classification_ctrl.sv
// rtl/classification_ctrl.sv - classification pass sequencer: centroid load, point streaming, pipeline enables
module classification_ctrl #(
  parameter int addrWidth    = 8,
  parameter int centroid_num = 8,
  parameter int ram_latency  = 1,
  parameter int pipe_delay   = 2,
  localparam int SelW        = (centroid_num > 1) ? $clog2(centroid_num) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [addrWidth-1:0]    last_addr,
  output logic                    busy,
  output logic                    done,
  output logic [SelW-1:0]         centroid_sel,
  output logic [centroid_num-1:0] centroid_en,
  output logic                    ram_rd_en,
  output logic [addrWidth-1:0]    ram_addr,
  output logic                    ram_input_reg_en,
  output logic                    accumulators_en
);

  localparam int Depth = ram_latency + pipe_delay;
  localparam logic [SelW-1:0] SelLast = SelW'(centroid_num - 1);
  localparam logic [centroid_num-1:0] OneHot0 = centroid_num'(1);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_STREAM, S_DRAIN, S_DONE} state_t;

  state_t                 r_state;
  state_t                 w_next;
  logic [addrWidth-1:0]   r_last;
  logic [addrWidth-1:0]   r_addr;
  logic [SelW-1:0]        r_sel;
  logic [Depth-1:0]       r_sr;
  logic [Depth-1:0]       w_sr_next;
  logic                   w_rd;

  assign w_rd      = (r_state == S_STREAM);
  // Bit i of the valid pipe is the read strobe delayed by i+1 cycles.
  assign w_sr_next = (r_sr << 1) | Depth'(w_rd);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (start) w_next = S_LOAD;
      S_LOAD:   if (r_sel == SelLast) w_next = S_STREAM;
      S_STREAM: if (r_addr == r_last) w_next = S_DRAIN;
      // Leave once nothing remains in flight, so done lands right after the last accumulate.
      S_DRAIN:  if (w_sr_next == '0) w_next = S_DONE;
      S_DONE:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last <= '0;
      r_addr <= '0;
      r_sel  <= '0;
      r_sr   <= '0;
    end else begin
      r_sr <= w_sr_next;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_last <= last_addr;
            r_sel  <= '0;
          end
        end
        S_LOAD: begin
          r_sel <= r_sel + 1'b1;
          if (r_sel == SelLast) r_addr <= '0;
        end
        S_STREAM: begin
          // Hold on the final address so a full-RAM pass never wraps.
          if (r_addr != r_last) r_addr <= r_addr + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign busy             = (r_state != S_IDLE);
  assign done             = (r_state == S_DONE);
  assign centroid_sel     = (r_state == S_LOAD) ? r_sel : '0;
  assign centroid_en      = (r_state == S_LOAD) ? (OneHot0 << r_sel) : '0;
  assign ram_rd_en        = w_rd;
  assign ram_addr         = w_rd ? r_addr : '0;
  assign ram_input_reg_en = r_sr[ram_latency-1];
  assign accumulators_en  = r_sr[Depth-1];

endmodule

// File: tb/tb_classification_ctrl.sv
// tb/tb_classification_ctrl.sv - scoreboard bench for classification_ctrl with default parameters
module tb_classification_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] last_addr = 8'd0;
  logic       busy, done, ram_rd_en, ram_input_reg_en, accumulators_en;
  logic [2:0] centroid_sel;
  logic [7:0] centroid_en;
  logic [7:0] ram_addr;

  classification_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .last_addr(last_addr),
    .busy(busy), .done(done), .centroid_sel(centroid_sel), .centroid_en(centroid_en),
    .ram_rd_en(ram_rd_en), .ram_addr(ram_addr),
    .ram_input_reg_en(ram_input_reg_en), .accumulators_en(accumulators_en)
  );

  always #5 clk = ~clk;

  typedef struct {int cyc; int val;} ev_t;
  ev_t q_cen[$];
  ev_t q_rd[$];
  int  q_ire[$];
  int  q_acc[$];
  int  q_done[$];

  int cyc = 0;
  int checks = 0;
  int errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic spurious(input string name);
    checks++;
    errors++;
    $display("FAIL %s: unexpected assertion at cycle %0d", name, cyc);
  endtask

  // Expected event schedule for one pass with start sampled at the end of cycle c0.
  task automatic push_pass(input int c0, input int la);
    for (int i = 0; i < 8; i++) q_cen.push_back('{c0 + 1 + i, i});
    for (int a = 0; a <= la; a++) begin
      q_rd.push_back('{c0 + 9 + a, a});
      q_ire.push_back(c0 + 10 + a);
      q_acc.push_back(c0 + 12 + a);
    end
    q_done.push_back(c0 + la + 13);
  endtask

  // Monitor: every asserted output must match the head of its queue.
  always @(negedge clk) begin
    ev_t e;
    int  c;
    if (centroid_en != 8'd0) begin
      if (q_cen.size() == 0) spurious("centroid_en");
      else begin
        e = q_cen.pop_front();
        chk("centroid_en_cycle", cyc, e.cyc);
        chk("centroid_en_value", int'(centroid_en), 1 << e.val);
        chk("centroid_sel", int'(centroid_sel), e.val);
        chk("busy_load", int'(busy), 1);
      end
    end
    if (ram_rd_en) begin
      if (q_rd.size() == 0) spurious("ram_rd_en");
      else begin
        e = q_rd.pop_front();
        chk("ram_rd_cycle", cyc, e.cyc);
        chk("ram_addr", int'(ram_addr), e.val);
      end
    end
    if (ram_input_reg_en) begin
      if (q_ire.size() == 0) spurious("ram_input_reg_en");
      else begin
        c = q_ire.pop_front();
        chk("ram_input_reg_en_cycle", cyc, c);
      end
    end
    if (accumulators_en) begin
      if (q_acc.size() == 0) spurious("accumulators_en");
      else begin
        c = q_acc.pop_front();
        chk("accumulators_en_cycle", cyc, c);
      end
    end
    if (done) begin
      if (q_done.size() == 0) spurious("done");
      else begin
        c = q_done.pop_front();
        chk("done_cycle", cyc, c);
        chk("busy_at_done", int'(busy), 1);
      end
    end
  end

  function automatic int pending();
    return q_cen.size() + q_rd.size() + q_ire.size() + q_acc.size() + q_done.size();
  endfunction

  task automatic wait_drain(input string name, input int budget);
    int n = 0;
    while (pending() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (pending() != 0) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: %0d events outstanding, expected 0", name, pending());
      q_cen.delete(); q_rd.delete(); q_ire.delete(); q_acc.delete(); q_done.delete();
    end
    repeat (4) @(negedge clk);
    chk({name, "_idle_busy"}, int'(busy), 0);
  endtask

  task automatic check_all_zero(input string name);
    chk({name, "_busy"}, int'(busy), 0);
    chk({name, "_done"}, int'(done), 0);
    chk({name, "_centroid_en"}, int'(centroid_en), 0);
    chk({name, "_centroid_sel"}, int'(centroid_sel), 0);
    chk({name, "_ram_rd_en"}, int'(ram_rd_en), 0);
    chk({name, "_ram_addr"}, int'(ram_addr), 0);
    chk({name, "_ram_input_reg_en"}, int'(ram_input_reg_en), 0);
    chk({name, "_accumulators_en"}, int'(accumulators_en), 0);
  endtask

  // Drive start for one cycle; returns the cycle in which start was sampled.
  task automatic launch(input int la, output int c0);
    @(negedge clk);
    c0 = cyc;
    start = 1'b1;
    last_addr = 8'(la);
    push_pass(c0, la);
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    int c0;

    repeat (3) @(negedge clk);
    check_all_zero("reset_hold");
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check_all_zero("reset_release");

    launch(3, c0);
    wait_drain("basic", 100);

    launch(0, c0);
    wait_drain("single", 100);

    launch(255, c0);
    wait_drain("full_ram", 400);

    // Extra start pulses and a last_addr change must not disturb the running pass.
    launch(10, c0);
    last_addr = 8'd2;
    while (cyc < c0 + 5) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (cyc < c0 + 20) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_drain("ignored_start", 100);

    // Reset in cycle 11 of a pass: only events before it may appear.
    @(negedge clk);
    c0 = cyc;
    start = 1'b1;
    last_addr = 8'd5;
    for (int i = 0; i < 8; i++) q_cen.push_back('{c0 + 1 + i, i});
    q_rd.push_back('{c0 + 9, 0});
    q_rd.push_back('{c0 + 10, 1});
    q_ire.push_back(c0 + 10);
    @(negedge clk);
    start = 1'b0;
    while (cyc < c0 + 10) @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    check_all_zero("mid_reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("mid_reset_leftover", pending(), 0);
    launch(3, c0);
    wait_drain("after_reset", 100);

    // start held high: the second pass samples start in the cycle after done.
    @(negedge clk);
    c0 = cyc;
    start = 1'b1;
    last_addr = 8'd2;
    push_pass(c0, 2);
    push_pass(c0 + 16, 2);
    while (cyc < c0 + 17) @(negedge clk);
    start = 1'b0;
    wait_drain("back_to_back", 100);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
